// File: rtl/sar_phase_decider.sv
// Majority-vote front end for the FMDLL 10-bit SAR loop controller.
// Build option: SAR_LOCK_MON_EN adds post-conversion tracking and lock monitor.
module sar_phase_decider #(
  parameter int VOTES    = 8,
  parameter int LOSS_RUN = 4
) (
  input  logic       clk4,
  input  logic       rst,
  input  logic       start,
  input  logic       pd_valid,
  input  logic       pd_lead,
  output logic       COMP,
  output logic       step,
  output logic       sar_clr,
  output logic [3:0] bit_idx,
  output logic       busy,
  output logic       done,
  output logic       tie,
  output logic       lock
);

  localparam int CW = $clog2(VOTES) + 1;
  localparam logic [CW-1:0] LAST = CW'(VOTES - 1);
  localparam logic [CW-1:0] HALF = CW'(VOTES / 2);

`ifdef SAR_LOCK_MON_EN
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_VOTE, S_DECIDE, S_DONE, S_TRACK
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_VOTE, S_DECIDE, S_DONE
  } state_t;
`endif

  state_t          state_q, state_d;
  logic            comp_q, comp_d;
  logic            step_q, step_d;
  logic            clr_q, clr_d;
  logic [3:0]      bit_q, bit_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            tie_q, tie_d;
  logic [CW-1:0]   smp_q, smp_d;
  logic [CW-1:0]   lead_q, lead_d;

  logic            dec_dir;
  logic            dec_tie;
  logic [CW-1:0]   smp_inc;
  logic [CW-1:0]   lead_inc;

  assign dec_dir  = (lead_q >= HALF);
  assign dec_tie  = (lead_q == HALF);
  assign smp_inc  = smp_q + CW'(1);
  assign lead_inc = lead_q + CW'(pd_lead);

`ifdef SAR_LOCK_MON_EN
  localparam logic [3:0] LOSS_N = 4'(LOSS_RUN);
  logic            lock_q, lock_d;
  logic            pend_q, pend_d;
  logic [3:0]      run_q, run_d;
`else
  logic            unused_loss;
  assign unused_loss = (LOSS_RUN > 0);
`endif

  always_ff @(posedge clk4) begin
    if (rst) begin
      state_q <= S_IDLE;
      comp_q  <= 1'b0;
      step_q  <= 1'b0;
      clr_q   <= 1'b0;
      bit_q   <= 4'd9;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tie_q   <= 1'b0;
      smp_q   <= '0;
      lead_q  <= '0;
`ifdef SAR_LOCK_MON_EN
      lock_q  <= 1'b0;
      pend_q  <= 1'b0;
      run_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      comp_q  <= comp_d;
      step_q  <= step_d;
      clr_q   <= clr_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tie_q   <= tie_d;
      smp_q   <= smp_d;
      lead_q  <= lead_d;
`ifdef SAR_LOCK_MON_EN
      lock_q  <= lock_d;
      pend_q  <= pend_d;
      run_q   <= run_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    comp_d  = comp_q;
    step_d  = 1'b0;
    clr_d   = 1'b0;
    bit_d   = bit_q;
    busy_d  = busy_q;
    done_d  = done_q;
    tie_d   = 1'b0;
    smp_d   = smp_q;
    lead_d  = lead_q;
`ifdef SAR_LOCK_MON_EN
    lock_d  = lock_q;
    pend_d  = pend_q;
    run_d   = run_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        clr_d   = 1'b1;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        bit_d   = 4'd9;
        smp_d   = '0;
        lead_d  = '0;
        state_d = S_VOTE;
      end
      S_VOTE: begin
        if (pd_valid) begin
          smp_d  = smp_inc;
          lead_d = lead_inc;
          if (smp_q == LAST) state_d = S_DECIDE;
        end
      end
      S_DECIDE: begin
        comp_d = dec_dir;
        tie_d  = dec_tie;
        step_d = 1'b1;
        smp_d  = '0;
        lead_d = '0;
        if (bit_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          bit_d   = bit_q - 4'd1;
          state_d = S_VOTE;
        end
      end
      S_DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
`ifdef SAR_LOCK_MON_EN
        lock_d  = 1'b1;
        pend_d  = 1'b0;
        run_d   = 4'd0;
        state_d = S_TRACK;
`else
        if (start) state_d = S_CLEAR;
`endif
      end
`ifdef SAR_LOCK_MON_EN
      S_TRACK: begin
        // pend_q marks the decide cycle; samples arriving then are dropped
        if (pend_q) begin
          comp_d = dec_dir;
          tie_d  = dec_tie;
          step_d = 1'b1;
          smp_d  = '0;
          lead_d = '0;
          pend_d = 1'b0;
          if (run_q != 4'd0 && dec_dir == comp_q) run_d = run_q + 4'd1;
          else run_d = 4'd1;
          if (run_d == LOSS_N) begin
            lock_d  = 1'b0;
            done_d  = 1'b0;
            state_d = S_CLEAR;
          end
        end else if (pd_valid) begin
          smp_d  = smp_inc;
          lead_d = lead_inc;
          if (smp_q == LAST) pend_d = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign COMP    = comp_q;
  assign step    = step_q;
  assign sar_clr = clr_q;
  assign bit_idx = bit_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign tie     = tie_q;
`ifdef SAR_LOCK_MON_EN
  assign lock    = lock_q;
`else
  assign lock    = 1'b0;
`endif

endmodule

// File: doc/sar_phase_decider.md
# sar_phase_decider

Decision front end that feeds the 10-bit SAR loop controller in the FMDLL. It accepts raw bang-bang phase-detector samples and majority-votes them into one clean `COMP` decision per SAR bit. It also produces the per-bit `step` strobe, the SAR restart pulse, and the conversion status. With the lock monitor compiled in, it keeps tracking after conversion and restarts the SAR when phase drifts.

## Interface
- `VOTES`, default 8: PD samples per decision; even, 2..64.
- `LOSS_RUN`, default 4: consecutive same-direction tracking decisions that declare loss of lock; 2..15.
- `clk4`  in  1  loop clock, shared with the SAR; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a conversion; sampled only in IDLE.
- `pd_valid`  in  1  PD sample qualifier.
- `pd_lead`  in  1  PD sample: 1 = lead, 0 = lag; meaningful only with `pd_valid`.
- `COMP`  out  1  registered decision to the SAR: 1 = lead, 0 = lag.
- `step`  out  1  one-cycle pulse; `COMP` is new and valid for this SAR bit.
- `sar_clr`  out  1  one-cycle pulse; SAR restarts at code 10'b1000000000, bit 9.
- `bit_idx`  out  4  bit under decision, 9 down to 0.
- `busy`  out  1  conversion in progress.
- `done`  out  1  all 10 bits decided; held.
- `tie`  out  1  one-cycle pulse alongside `step` when the vote was exactly VOTES/2.
- `lock`  out  1  tracking and in lock (lock-monitor builds only).

## Operation
- States: IDLE, CLEAR, VOTE, DECIDE, DONE; TRACK exists with the lock monitor only.
- IDLE: `start`=1 -> CLEAR.
- CLEAR: assert `sar_clr` for one cycle, load `bit_idx`=9, clear counters, raise `busy` -> VOTE.
- VOTE:
  - Each `pd_valid` cycle increments `smp_cnt`, and increments `lead_cnt` when `pd_lead`=1.
  - When the VOTES-th sample is accepted -> DECIDE.
- DECIDE:
  - `COMP` <= (`lead_cnt` >= VOTES/2). A tie resolves to lead (1) and pulses `tie`.
  - Pulse `step`; clear counters.
  - If `bit_idx`=0 -> DONE; otherwise `bit_idx` decrements -> VOTE.
- DONE: `busy`=0, `done`=1, `COMP` held.
  - Without the monitor: `start` -> CLEAR, which clears `done`.
  - With the monitor -> TRACK.
- Counter widths: `smp_cnt` and `lead_cnt` are clog2(VOTES)+1 bits; both reset to 0 in CLEAR and DECIDE. No wrap is possible.
- `pd_valid` in CLEAR, DECIDE or DONE: sample dropped, not counted.
- `start` outside IDLE/DONE: ignored.

## Timing
- Reset: `COMP`=0, `step`=0, `sar_clr`=0, `bit_idx`=9, `busy`=0, `done`=0, `tie`=0, `lock`=0; state IDLE.
- `start` on edge N: `sar_clr` and `busy` are high after edge N+1; VOTE begins at edge N+2.
- Vote latency: the last valid sample is accepted at edge M; `COMP` and `step` are updated at edge M+1. `step` is high for exactly one cycle.
- With `pd_valid` held high, one bit takes VOTES+1 cycles. A full conversion takes 2+10·(VOTES+1) cycles from `start`.
- `rst` mid-conversion: reset values at the next edge; the partial vote is discarded; no `step` or `sar_clr` pulse is emitted.

## Configuration
- Macro: `SAR_LOCK_MON_EN`.
- Defined — after DONE, enter TRACK:
  - Keep voting VOTES samples per decision and pulse `step` per decision.
  - Set `lock`=1 on entry.
  - Track consecutive equal decisions in a 4-bit `run_cnt`; it resets to 1 when the direction changes.
  - When `run_cnt` reaches LOSS_RUN: `lock`=0, `done`=0 -> CLEAR. This is a full reconversion.
  - `start` in TRACK is ignored.
- Undefined: no TRACK state and no `run_cnt`; `lock` is tied to 0; DONE waits for `start`.

## Test plan
- Reset, idle: hold `rst`=1 for 2 cycles with random `pd_valid`/`pd_lead` -> all outputs at reset values; no `step` or `sar_clr`.
- Basic conversion: VOTES=4; `start`, then `pd_valid`=1 continuously with `pd_lead`=1,1,1,0 per bit -> `sar_clr` once, then 10 `step` pulses each with `COMP`=1 and 5 cycles apart. `bit_idx` runs 9..0; `done`=1 at cycle 52.
- Tie and gaps: VOTES=4, samples lead,lag,lead,lag with `pd_valid` low every other cycle -> `COMP`=1 and `tie` pulses with `step`; the decision lands one cycle after the 4th valid sample.
- Reset mid-conversion: assert `rst` while `bit_idx`=5 -> `bit_idx`=9, `busy`=0, no `step` pulse. A following `start` produces a fresh `sar_clr`.
- Lock loss (`SAR_LOCK_MON_EN`, LOSS_RUN=4): after `done`, feed alternating-direction decisions -> `lock` stays 1. Then feed 4 lag decisions -> `lock`=0, `sar_clr` pulse, `busy`=1, `bit_idx`=9.
- Monitor disabled: the same stimulus as the lock-loss case -> `lock`=0 throughout, no restart, `done` stays 1 until `start`.
